// File: rtl/dma_dat_rd_cmd_gen.sv
// DMA data-read command generator: walks surface/burst/group/row loops and emits {len, base, offset} bursts.
// Latency: first command valid one cycle after start; one command per cycle while rd_req_rdy is high.
// Backpressure: rd_req_pd is held while vld & !rdy; with DMA_DAT_OUTST_LIMIT_EN, vld is withheld at MAX_OUTST credits.
module dma_dat_rd_cmd_gen #(
  parameter int ADDR_W     = 32,
  parameter int LOG2_BURST = 4,
  parameter int PIX_BYTES  = 8,
  parameter int W_W        = 12,
  parameter int H_W        = 12,
  parameter int GRP_W      = 8,
  parameter int SG_W       = 5,
  parameter int MAX_OUTST  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [W_W-1:0]                 win,
  input  logic [H_W-1:0]                 hin,
  input  logic [GRP_W-1:0]               grp_num,
  input  logic [SG_W-1:0]                grp_sz_m1,
  input  logic [SG_W-1:0]                grp_res_m1,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [ADDR_W-1:0]              surf_stride,
  input  logic [ADDR_W-1:0]              line_stride,
  output logic                           rd_req_vld,
  input  logic                           rd_req_rdy,
  output logic [LOG2_BURST+2*ADDR_W-1:0] rd_req_pd,
  input  logic                           rd_rsp_done,
  output logic                           busy,
  output logic                           done
);

  localparam int BURST = 1 << LOG2_BURST;
  localparam int PD_W  = LOG2_BURST + 2 * ADDR_W;
  localparam logic [ADDR_W-1:0]     K_STEP   = ADDR_W'(BURST * PIX_BYTES);
  localparam logic [LOG2_BURST-1:0] LEN_FULL = '1;

  // job configuration captured at start
  logic [W_W-1:0]        klast_q, klast_d;
  logic [LOG2_BURST-1:0] lenlast_q, lenlast_d;
  logic [H_W-1:0]        hlast_q, hlast_d;
  logic [GRP_W-1:0]      glast_q, glast_d;
  logic [SG_W-1:0]       gsz_q, gsz_d, gres_q, gres_d;
  logic [ADDR_W-1:0]     base_q, base_d, ss_q, ss_d, ls_q, ls_d;

  // loop counters of the command currently held in rd_req_pd, and their address biases
  logic [SG_W-1:0]   kk_q, kk_d;
  logic [W_W-1:0]    k_q, k_d;
  logic [GRP_W-1:0]  g_q, g_d;
  logic [H_W-1:0]    h_q, h_d;
  logic [ADDR_W-1:0] kkb_q, kkb_d, kb_q, kb_d, gb_q, gb_d, hb_q, hb_d;

  logic            busy_q, busy_d, done_q, done_d, vld_q, vld_d, have_q, have_d;
  logic [PD_W-1:0] pd_q, pd_d;

  logic            hs, start_ok, zero_job, last_cmd;
  logic            kk_end, k_end, g_end, h_end;
  logic [SG_W-1:0] kk_lim;
  logic [W_W-1:0]  win_m1;
  logic [W_W-1:0]  klast_in;
  logic [LOG2_BURST-1:0] len_n;

  assign hs       = vld_q & rd_req_rdy;
  assign start_ok = start & ~busy_q & ~abort;
  assign zero_job = (win == '0) | (hin == '0) | (grp_num == '0);
  assign win_m1   = win - W_W'(1);
  assign klast_in = win_m1 >> LOG2_BURST;
  assign kk_lim   = (g_q == glast_q) ? gres_q : gsz_q;
  assign kk_end   = (kk_q == kk_lim);
  assign k_end    = (k_q == klast_q);
  assign g_end    = (g_q == glast_q);
  assign h_end    = (h_q == hlast_q);
  assign last_cmd = kk_end & k_end & g_end & h_end;

  // next-state: job launch, abort, and loop advance on each handshake
  always_comb begin
    klast_d   = klast_q;
    lenlast_d = lenlast_q;
    hlast_d   = hlast_q;
    glast_d   = glast_q;
    gsz_d     = gsz_q;
    gres_d    = gres_q;
    base_d    = base_q;
    ss_d      = ss_q;
    ls_d      = ls_q;
    kk_d      = kk_q;
    k_d       = k_q;
    g_d       = g_q;
    h_d       = h_q;
    kkb_d     = kkb_q;
    kb_d      = kb_q;
    gb_d      = gb_q;
    hb_d      = hb_q;
    busy_d    = busy_q;
    have_d    = have_q;
    pd_d      = pd_q;
    done_d    = 1'b0;
    len_n     = LEN_FULL;

    if (abort & busy_q) begin
      busy_d = 1'b0;
      have_d = 1'b0;
      kk_d = '0; k_d = '0; g_d = '0; h_d = '0;
      kkb_d = '0; kb_d = '0; gb_d = '0; hb_d = '0;
    end else if (start_ok) begin
      klast_d   = klast_in;
      lenlast_d = win_m1[LOG2_BURST-1:0];
      hlast_d   = hin - H_W'(1);
      glast_d   = grp_num - GRP_W'(1);
      gsz_d     = grp_sz_m1;
      gres_d    = grp_res_m1;
      base_d    = base_addr;
      ss_d      = surf_stride;
      ls_d      = line_stride;
      kk_d = '0; k_d = '0; g_d = '0; h_d = '0;
      kkb_d = '0; kb_d = '0; gb_d = '0; hb_d = '0;
      if (zero_job) begin
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        have_d = 1'b1;
        len_n  = (klast_in == '0) ? win_m1[LOG2_BURST-1:0] : LEN_FULL;
        pd_d   = {len_n, base_addr, {ADDR_W{1'b0}}};
      end
    end else if (hs) begin
      if (last_cmd) begin
        busy_d = 1'b0;
        have_d = 1'b0;
        done_d = 1'b1;
        kk_d = '0; k_d = '0; g_d = '0; h_d = '0;
        kkb_d = '0; kb_d = '0; gb_d = '0; hb_d = '0;
      end else begin
        if (!kk_end) begin
          kk_d  = kk_q + 1'b1;
          kkb_d = kkb_q + ss_q;
        end else begin
          kk_d  = '0;
          kkb_d = '0;
          if (!k_end) begin
            k_d  = k_q + 1'b1;
            kb_d = kb_q + K_STEP;
          end else begin
            k_d  = '0;
            kb_d = '0;
            if (!g_end) begin
              // a full group spans (grp_sz_m1+1) surfaces: last kk bias plus one more stride
              g_d  = g_q + 1'b1;
              gb_d = gb_q + kkb_q + ss_q;
            end else begin
              g_d  = '0;
              gb_d = '0;
              h_d  = h_q + 1'b1;
              hb_d = hb_q + ls_q;
            end
          end
        end
        len_n  = (k_d == klast_q) ? lenlast_q : LEN_FULL;
        have_d = 1'b1;
        pd_d   = {len_n, base_q, kkb_d + kb_d + gb_d + hb_d};
      end
    end
  end

`ifdef DMA_DAT_OUTST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // outstanding-burst credits; a new command is only presented below the limit
  always_comb begin
    cnt_d = cnt_q;
    if (hs & ~rd_rsp_done) begin
      cnt_d = cnt_q + 1'b1;
    end else if (~hs & rd_rsp_done & (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    vld_d = have_d & (cnt_d != CNT_W'(MAX_OUTST));
  end

  // credit counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_rsp;
  assign unused_rsp = rd_rsp_done | (MAX_OUTST < 0);

  // no credit limit: a held command is always presented
  always_comb begin
    vld_d = have_d;
  end
`endif

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      klast_q <= '0; lenlast_q <= '0; hlast_q <= '0; glast_q <= '0;
      gsz_q <= '0; gres_q <= '0; base_q <= '0; ss_q <= '0; ls_q <= '0;
      kk_q <= '0; k_q <= '0; g_q <= '0; h_q <= '0;
      kkb_q <= '0; kb_q <= '0; gb_q <= '0; hb_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; vld_q <= 1'b0; have_q <= 1'b0;
      pd_q <= '0;
    end else begin
      klast_q <= klast_d; lenlast_q <= lenlast_d; hlast_q <= hlast_d; glast_q <= glast_d;
      gsz_q <= gsz_d; gres_q <= gres_d; base_q <= base_d; ss_q <= ss_d; ls_q <= ls_d;
      kk_q <= kk_d; k_q <= k_d; g_q <= g_d; h_q <= h_d;
      kkb_q <= kkb_d; kb_q <= kb_d; gb_q <= gb_d; hb_q <= hb_d;
      busy_q <= busy_d; done_q <= done_d; vld_q <= vld_d; have_q <= have_d;
      pd_q <= pd_d;
    end
  end

  assign rd_req_vld = vld_q;
  assign rd_req_pd  = pd_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dma_dat_rd_cmd_gen.sv
// Bench for dma_dat_rd_cmd_gen: directed and random jobs against a nested-loop reference model.
// Outputs sampled on the falling edge; inputs driven right after it.
// Set DMA_DAT_OUTST_LIMIT_EN to also exercise the credit limit with MAX_OUTST=4.
module tb_dma_dat_rd_cmd_gen;

  localparam int TB_OUTST = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [11:0] win, hin;
  logic [7:0]  grp_num;
  logic [4:0]  grp_sz_m1, grp_res_m1;
  logic [31:0] base_addr, surf_stride, line_stride;
  logic        rd_req_vld, rd_req_rdy, rd_rsp_done, busy, done;
  logic [67:0] rd_req_pd;

  dma_dat_rd_cmd_gen #(.MAX_OUTST(TB_OUTST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .win(win), .hin(hin), .grp_num(grp_num), .grp_sz_m1(grp_sz_m1), .grp_res_m1(grp_res_m1),
    .base_addr(base_addr), .surf_stride(surf_stride), .line_stride(line_stride),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_pd(rd_req_pd),
    .rd_rsp_done(rd_rsp_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;
  int pend     = 0;

  int          c_win, c_hin, c_grp, c_gsz, c_gres;
  logic [31:0] c_base, c_ss, c_ls;
  logic [67:0] exp_q[$];
  logic [67:0] got[$];

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int g, input int sz, input int res,
                         input logic [31:0] b, input logic [31:0] ss, input logic [31:0] ls);
    c_win = w; c_hin = h; c_grp = g; c_gsz = sz; c_gres = res;
    c_base = b; c_ss = ss; c_ls = ls;
  endtask

  // reference: plain nested loops, row outermost, surface innermost
  task automatic build_model();
    int nb, ns;
    logic [31:0] off;
    logic [3:0]  len;
    exp_q.delete();
    if (c_win == 0 || c_hin == 0 || c_grp == 0) return;
    nb = (c_win + 15) / 16;
    for (int h = 0; h < c_hin; h++)
      for (int g = 0; g < c_grp; g++) begin
        ns = (g == c_grp - 1) ? c_gres + 1 : c_gsz + 1;
        for (int k = 0; k < nb; k++)
          for (int kk = 0; kk < ns; kk++) begin
            off = 32'(kk) * c_ss + 32'(g) * 32'(c_gsz + 1) * c_ss + 32'(h) * c_ls + 32'(k) * 32'd128;
            len = (k == nb - 1) ? 4'((c_win - 1) % 16) : 4'd15;
            exp_q.push_back({len, c_base, off});
          end
      end
  endtask

  task automatic start_job();
    build_model();
    while (pend > 0) begin
      rd_rsp_done = 1'b1;
      pend--;
      @(negedge clk);
    end
    rd_rsp_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; abort = 1'b0; rd_req_rdy = 1'b0;
    win = 12'(c_win); hin = 12'(c_hin); grp_num = 8'(c_grp);
    grp_sz_m1 = 5'(c_gsz); grp_res_m1 = 5'(c_gres);
    base_addr = c_base; surf_stride = c_ss; line_stride = c_ls;
    @(negedge clk);
    start = 1'b0;
    win = 12'($urandom); hin = 12'($urandom); grp_num = 8'($urandom);
    grp_sz_m1 = 5'($urandom); grp_res_m1 = 5'($urandom);
    base_addr = $urandom; surf_stride = $urandom; line_stride = $urandom;
  endtask

  // runs from the first falling edge after start; returns the cycle done was seen (-1 if none)
  task automatic collect(input int rdy_pct, input int abort_at, output int done_cyc, output int n_hs);
    logic        stalled, aborted;
    logic [67:0] prev;
    int          post;
    got.delete();
    done_cyc = -1; n_hs = 0; stalled = 1'b0; aborted = 1'b0; post = 0; prev = '0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      start = 1'b0; abort = 1'b0; rd_rsp_done = 1'b0;
      if (stalled) begin
        chk("vld_hold", rd_req_vld, 1'b1);
        chk("pd_hold", rd_req_pd, prev);
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", busy, 1'b0);
        break;
      end
      if (aborted) begin
        post++;
        if (post == 1) begin
          chk("abort_vld", rd_req_vld, 1'b0);
          chk("abort_busy", busy, 1'b0);
        end
        if (post == 20) break;
        @(negedge clk);
        continue;
      end
      if (cyc == 3) start = 1'b1;
      if (pend > 0) begin
        rd_rsp_done = 1'b1;
        pend--;
      end
      rd_req_rdy = ($urandom_range(99) < rdy_pct);
      if (rd_req_vld && rd_req_rdy) begin
        got.push_back(rd_req_pd);
        n_hs++;
        pend++;
        if (n_hs == abort_at) begin
          abort = 1'b1;
          aborted = 1'b1;
        end
      end
      stalled = rd_req_vld && !rd_req_rdy;
      prev = rd_req_pd;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; rd_rsp_done = 1'b0;
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(tag, got[i], exp_q[i]);
  endtask

  int dc, nh;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_req_rdy = 1'b0; rd_rsp_done = 1'b0;
    win = '0; hin = '0; grp_num = '0; grp_sz_m1 = '0; grp_res_m1 = '0;
    base_addr = '0; surf_stride = '0; line_stride = '0;

    // reset values before any clock edge
    #3;
    chk("rst_vld", rd_req_vld, 1'b0);
    chk("rst_pd", rd_req_pd, 68'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // reference job, full throughput
    set_cfg(40, 2, 2, 3, 1, 32'h8000_0000, 32'h1000, 32'h400);
    start_job();
    chk("A_busy", busy, 1'b1);
    collect(100, 0, dc, nh);
    chk("A_done_cyc", dc, 37);
    chk("A_n_cmd", nh, 36);
    cmp_seq("A_seq");
    chk("A_cmd5_off", got[4][31:0], 32'h80);
    chk("A_g1_off", got[12][31:0], 32'h4000);
    chk("A_base", got[0][63:32], 32'h8000_0000);
    chk("A_len_last", got[8][67:64], 4'd7);
    @(negedge clk);
    chk("A_done_pulse", done, 1'b0);

    // same job under sparse ready
    start_job();
    collect(30, 0, dc, nh);
    chk("B_n_cmd", nh, 36);
    chk("B_done_seen", dc > 0, 1'b1);
    cmp_seq("B_seq");

    // abort at the 10th handshake, then a clean rerun
    start_job();
    collect(100, 10, dc, nh);
    chk("C_n_cmd", nh, 10);
    chk("C_no_done", dc < 0, 1'b1);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("C_prefix", got[i], exp_q[i]);
    start_job();
    collect(100, 0, dc, nh);
    chk("C2_done_cyc", dc, 37);
    cmp_seq("C2_seq");

    // asynchronous reset mid-job, start on the first edge after release
    start_job();
    rd_req_rdy = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", rd_req_vld, 1'b0);
    chk("arst_pd", rd_req_pd, 68'd0);
    chk("arst_busy", busy, 1'b0);
    pend = 0;
    start_job();
    collect(100, 0, dc, nh);
    chk("R_done_cyc", dc, 37);
    cmp_seq("R_seq");

    // degenerate jobs: no command, done next cycle
    for (int z = 0; z < 3; z++) begin
      set_cfg(z == 0 ? 0 : 40, z == 1 ? 0 : 2, z == 2 ? 0 : 2, 3, 1, 32'h1234_0000, 32'h1000, 32'h400);
      start_job();
      collect(100, 0, dc, nh);
      chk("Z_done_cyc", dc, 1);
      chk("Z_n_cmd", nh, 0);
    end

    // exact-burst row width: every len is full
    set_cfg(16, 3, 1, 2, 2, 32'h0, 32'h800, 32'h100);
    start_job();
    collect(70, 0, dc, nh);
    cmp_seq("W16_seq");
    for (int i = 0; i < got.size(); i++) chk("W16_len", got[i][67:64], 4'd15);

    // random configurations
    for (int r = 0; r < 4; r++) begin
      set_cfg($urandom_range(50, 1), $urandom_range(3, 1), $urandom_range(3, 1),
              $urandom_range(3, 0), $urandom_range(3, 0), $urandom, $urandom, $urandom);
      start_job();
      collect(50, 0, dc, nh);
      chk("RND_done_seen", dc > 0, 1'b1);
      cmp_seq("RND_seq");
    end

`ifdef DMA_DAT_OUTST_LIMIT_EN
    // credit limit with no responses returned
    set_cfg(40, 2, 2, 3, 1, 32'h8000_0000, 32'h1000, 32'h400);
    start_job();
    got.delete();
    nh = 0;
    rd_req_rdy = 1'b1;
    repeat (20) begin
      if (rd_req_vld && rd_req_rdy) begin got.push_back(rd_req_pd); nh++; end
      @(negedge clk);
    end
    chk("CR_n_cmd", nh, TB_OUTST);
    chk("CR_vld_low", rd_req_vld, 1'b0);
    rd_rsp_done = 1'b1;
    @(negedge clk);
    rd_rsp_done = 1'b0;
    repeat (10) begin
      if (rd_req_vld && rd_req_rdy) begin got.push_back(rd_req_pd); nh++; end
      @(negedge clk);
    end
    chk("CR_n_cmd2", nh, TB_OUTST + 1);
    chk("CR_vld_low2", rd_req_vld, 1'b0);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("CR_seq", got[i], exp_q[i]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("CR_abort_busy", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_dat_rd_cmd_gen.md
DMA_DAT_RD_CMD_GEN -- requirements
Module: dma_dat_rd_cmd_gen

Interface
REQ-001 SHALL take parameter ADDR_W, default 32: width of base and offset addresses.
REQ-002 SHALL take parameter LOG2_BURST, default 4: burst length BURST = 2^LOG2_BURST pixels.
REQ-003 SHALL take parameter PIX_BYTES, default 8: bytes per pixel beat.
REQ-004 SHALL take parameters W_W, H_W, GRP_W, SG_W, defaults 12, 12, 8, 5: widths of the Win, Hin, group-count and surfaces-per-group fields.
REQ-005 SHALL take parameter MAX_OUTST, default 8: outstanding-burst limit; only used under REQ-030.
REQ-006 SHALL have clk  in  1  clock.
REQ-007 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have start  in  1  one-cycle job launch.
REQ-009 SHALL have abort  in  1  one-cycle job cancel.
REQ-010 SHALL have win  in  W_W  row width in pixels, and hin  in  H_W  row count.
REQ-011 SHALL have grp_num  in  GRP_W  channel-group count; grp_sz_m1  in  SG_W  surfaces per full group minus 1; grp_res_m1  in  SG_W  surfaces in last group minus 1.
REQ-012 SHALL have base_addr  in  ADDR_W; surf_stride  in  ADDR_W; line_stride  in  ADDR_W.
REQ-013 SHALL have rd_req_vld  out  1; rd_req_rdy  in  1; rd_req_pd  out  LOG2_BURST+2*ADDR_W  {len, base_addr, offset}.
REQ-014 SHALL have rd_rsp_done  in  1  one pulse per completed burst.
REQ-015 SHALL have busy  out  1 and done  out  1  one-cycle job-complete pulse.

Function
REQ-016 SHALL sample all configuration inputs into internal registers on accepted start; inputs may then change freely.
REQ-017 SHALL accept start only when busy==0; start while busy SHALL be ignored.
REQ-018 SHALL issue commands in nested order, innermost first: surface kk in group (0..grp_sz_m1, or grp_res_m1 for last group), burst k in row (0..ceil(win/BURST)-1), group g (0..grp_num-1), row h (0..hin-1).
REQ-019 SHALL compute offset = kk*surf_stride + g*(grp_sz_m1+1)*surf_stride + h*line_stride + k*BURST*PIX_BYTES, modulo 2^ADDR_W, using incrementally accumulated biases only (no multipliers except the constant shift).
REQ-020 SHALL set len = BURST-1 except on the last burst of a row, where len = (win-1) mod BURST.
REQ-021 SHALL register rd_req_vld and rd_req_pd; first command valid in the cycle after start is accepted.
REQ-022 SHALL hold rd_req_pd stable while rd_req_vld=1 and rd_req_rdy=0; counters advance only on vld&rdy.
REQ-023 SHALL sustain one command per cycle when rd_req_rdy is held high and no credit stall applies.
REQ-024 SHALL raise done for one cycle in the cycle after the last handshake, clearing busy in that same cycle.
REQ-025 SHALL, if win, hin or grp_num is 0 at start, issue no command and pulse done in the next cycle.
REQ-026 SHALL, on abort while busy, deassert rd_req_vld and busy in the next cycle, not pulse done, and reset all loop counters and biases; abort when idle SHALL have no effect; abort and start together SHALL be treated as abort.

Reset
REQ-027 SHALL on rst_n=0 force rd_req_vld=0, rd_req_pd=0, busy=0, done=0, all counters, biases and credit count to 0, regardless of clk.
REQ-028 SHALL after reset release accept start in the first clock edge.

Configuration
REQ-029 SHALL use macro DMA_DAT_OUTST_LIMIT_EN.
REQ-030 SHALL with the macro defined: keep credit counter, +1 on handshake, -1 on rd_rsp_done, unchanged on both; hold rd_req_vld low before presenting a new command while count==MAX_OUTST; done still follows REQ-024 without waiting for responses.
REQ-031 SHALL with the macro undefined: have no credit counter, ignore rd_rsp_done, never stall on credits.

Verification
REQ-032 SHALL cover: win=40, hin=2, grp_num=2, grp_sz_m1=3, grp_res_m1=1, rdy=1 -> 36 commands, lens 15,15,7 per surface sweep, done at cycle 37 after start.
REQ-033 SHALL cover: surf_stride=0x1000, line_stride=0x400, base 0x8000_0000, command #5 of REQ-032 -> offset 0x80 (k=1,kk=0)... command of g=1,kk=0,h=0 -> offset 0x4000.
REQ-034 SHALL cover: random rdy toggling, 30% high -> pd never changes while vld&!rdy, sequence identical to REQ-032.
REQ-035 SHALL cover: abort at 10th handshake -> vld=0 next cycle, no done; new start then yields full REQ-032 sequence from offset 0.
REQ-036 SHALL cover: macro defined, MAX_OUTST=4, no rd_rsp_done -> exactly 4 handshakes then vld low; one rd_rsp_done -> exactly one more command.
REQ-037 SHALL cover: win=0 -> no vld, done one cycle after start; win=16 -> all lens 15.
